// File: rtl/spy_path_measure.sv
// spy_path_measure: launch/capture delay measurement controller for a spy chain.
// Define SPY_MINMAX_EN to add delay_min/delay_max tracking ports.
module spy_path_measure #(
    parameter int CNT_W       = 16,
    parameter int TRIALS_LOG2 = 4,
    parameter int TIMEOUT     = 1023,
    parameter int SETTLE_CYC  = 8,
    parameter bit EXPECT_INV  = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         launch,
    input  logic                         result_in,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err,
    output logic                         settle_err,
    output logic [CNT_W-1:0]             delay_last,
    output logic [CNT_W+TRIALS_LOG2-1:0] delay_sum,
`ifdef SPY_MINMAX_EN
    output logic [CNT_W-1:0]             delay_min,
    output logic [CNT_W-1:0]             delay_max,
`endif
    output logic [TRIALS_LOG2:0]         trial_cnt
);
    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, RECORD, FIN} state_t;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [TRIALS_LOG2:0] LAST_TRIAL = (TRIALS_LOG2 + 1)'(2 ** TRIALS_LOG2 - 1);
    state_t state, next;
    logic sync1, res_s, match, settle_last;
    logic [CNT_W-1:0] cnt;
    assign match = res_s == (launch ^ EXPECT_INV);
    assign settle_last = cnt == SETTLE_LAST;
    assign busy = state != IDLE;
    assign done = state == FIN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? SETTLE : IDLE;
            SETTLE:  next = !settle_last ? SETTLE : match ? LAUNCH : FIN;
            LAUNCH:  next = WAIT;
            WAIT:    next = match ? RECORD : cnt == CNT_MAX ? FIN : WAIT;
            RECORD:  next = trial_cnt == LAST_TRIAL ? FIN : SETTLE;
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
    end
    // cnt doubles as the settle timer and the per-trial delay counter; it
    // freezes once the new level arrives so RECORD captures the arrival cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b0;
            res_s       <= 1'b0;
            cnt         <= '0;
            launch      <= 1'b0;
            timeout_err <= 1'b0;
            settle_err  <= 1'b0;
            delay_last  <= '0;
            delay_sum   <= '0;
            trial_cnt   <= '0;
`ifdef SPY_MINMAX_EN
            delay_min   <= '0;
            delay_max   <= '0;
`endif
        end else begin
            sync1 <= result_in;
            res_s <= sync1;
            case (state)
                IDLE: if (start) begin
                    cnt         <= '0;
                    timeout_err <= 1'b0;
                    settle_err  <= 1'b0;
                    delay_last  <= '0;
                    delay_sum   <= '0;
                    trial_cnt   <= '0;
`ifdef SPY_MINMAX_EN
                    delay_min   <= '1;
                    delay_max   <= '0;
`endif
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (settle_last && !match)
                        settle_err <= 1'b1;
                end
                LAUNCH: begin
                    launch <= ~launch;
                    cnt    <= '0;
                end
                WAIT: if (!match) begin
                    if (cnt == CNT_MAX)
                        timeout_err <= 1'b1;
                    else
                        cnt <= cnt + 1'b1;
                end
                RECORD: begin
                    delay_last <= cnt;
                    delay_sum  <= delay_sum + (CNT_W + TRIALS_LOG2)'(cnt);
                    trial_cnt  <= trial_cnt + 1'b1;
                    cnt        <= '0;
`ifdef SPY_MINMAX_EN
                    if (cnt < delay_min)
                        delay_min <= cnt;
                    if (cnt > delay_max)
                        delay_max <= cnt;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spy_path_measure.sv
// tb_spy_path_measure: randomized chain-delay runs against a cycle-delay chain model,
// plus directed timeout, settle-error, start-ignore and mid-run reset scenarios.
module tb_spy_path_measure;
    localparam int CNT_W = 16;
    localparam int TL = 2;
    localparam int NT = 4;
    localparam int SETTLE_CYC = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, result_in;
    logic launch, busy, done, timeout_err, settle_err;
    logic [CNT_W-1:0] delay_last;
    logic [CNT_W+TL-1:0] delay_sum;
    logic [TL:0] trial_cnt;
`ifdef SPY_MINMAX_EN
    logic [CNT_W-1:0] delay_min, delay_max;
`endif
    int npass = 0, nchk = 0;
    int mode = 0;
    int dly [0:63];
    logic [15:0] hist = '0;
    logic lprev = 1'b0;
    int ntog = 0, ndone = 0;

    spy_path_measure #(.CNT_W(CNT_W), .TRIALS_LOG2(TL), .TIMEOUT(1023), .SETTLE_CYC(SETTLE_CYC), .EXPECT_INV(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .launch(launch), .result_in(result_in),
        .busy(busy), .done(done), .timeout_err(timeout_err), .settle_err(settle_err),
        .delay_last(delay_last), .delay_sum(delay_sum),
`ifdef SPY_MINMAX_EN
        .delay_min(delay_min), .delay_max(delay_max),
`endif
        .trial_cnt(trial_cnt)
    );

    always #5 clk = ~clk;

    // chain model: output follows launch after dly[k] clock edges, k = toggle index
    always @(posedge clk) begin
        hist  <= {hist[14:0], launch};
        lprev <= launch;
        if (launch !== lprev) ntog <= ntog + 1;
        if (done) ndone <= ndone + 1;
    end
    assign result_in = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : hist[4'(dly[ntog] - 1)];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic run_wait(input int budget, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on", busy, 1);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic chain_run(input int d0, input int d1, input int d2, input int d3, input bit poke);
        int d[4];
        int base, nd0, cyc, lim, mn, mx;
        longint sum;
        d = '{d0, d1, d2, d3};
        base = ntog;
        nd0 = ndone;
        sum = 0;
        mn = 65535;
        mx = 0;
        for (int i = 0; i < NT; i++) begin
            dly[base + 1 + i] = d[i];
            sum += d[i] + 2;
            mn = (d[i] + 2 < mn) ? d[i] + 2 : mn;
            mx = (d[i] + 2 > mx) ? d[i] + 2 : mx;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on", busy, 1);
        cyc = 0;
        if (poke) begin
            lim = 0;
            while (ntog == base && lim < 100) begin
                @(negedge clk);
                lim++;
            end
            check("poke_in_wait", launch, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (!done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 1);
        check("delay_last", delay_last, d3 + 2);
        check("delay_sum", delay_sum, sum);
        check("trial_cnt", trial_cnt, NT);
        check("timeout_err", timeout_err, 0);
        check("settle_err", settle_err, 0);
`ifdef SPY_MINMAX_EN
        check("delay_min", delay_min, mn);
        check("delay_max", delay_max, mx);
`endif
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("busy_off", busy, 0);
        repeat (5) @(negedge clk);
        check("stays_idle", busy, 0);
        check("done_pulses", ndone - nd0, 1);
        check("sum_hold", delay_sum, sum);
    endtask

    initial begin
        int cyc, base, lim;
        for (int i = 0; i < 64; i++) dly[i] = 5;
        repeat (3) @(negedge clk);
        check("rst_launch", launch, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_settle", settle_err, 0);
        check("rst_last", delay_last, 0);
        check("rst_sum", delay_sum, 0);
        check("rst_trials", trial_cnt, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        chain_run(5, 5, 5, 5, 1'b0);
        chain_run(3, 6, 4, 5, 1'b0);
        for (int r = 0; r < 3; r++)
            chain_run($urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(12, 1), 1'b0);
        chain_run($urandom_range(12, 3), $urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(12, 1), 1'b1);

        mode = 1;
        do_reset();
        run_wait(1200, cyc);
        check("tmo_err", timeout_err, 1);
        check("tmo_settle", settle_err, 0);
        check("tmo_trials", trial_cnt, 0);
        check("tmo_sum", delay_sum, 0);
        check("tmo_launched", launch, 1);
        check("tmo_long", cyc > 1000, 1);
        @(negedge clk);
        check("tmo_idle", busy, 0);

        mode = 2;
        do_reset();
        base = ntog;
        run_wait(100, cyc);
        check("settle_err", settle_err, 1);
        check("settle_tmo", timeout_err, 0);
        check("settle_trials", trial_cnt, 0);
        check("settle_launch", launch, 0);
        check("settle_no_toggle", ntog - base, 0);
        check("settle_latency", cyc, SETTLE_CYC);

        mode = 0;
        do_reset();
        base = ntog;
        for (int i = 1; i <= NT; i++) dly[base + i] = 6;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lim = 0;
        while ((trial_cnt != 2 || !launch) && lim < 500) begin
            @(negedge clk);
            lim++;
        end
        check("mid_trials", trial_cnt, 2);
        check("mid_sum", delay_sum, 16);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_launch", launch, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", delay_sum, 0);
        check("mid_rst_trials", trial_cnt, 0);
        check("mid_rst_last", delay_last, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
